// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic TXDATA_OFF = 1'b0;
    localparam logic STATUS_OFF = 1'b1;

    localparam int unsigned FULL_BIT  = 0;
    localparam int unsigned EMPTY_BIT = 1;
    localparam int unsigned BUSY_BIT  = 2;
    localparam int unsigned OVF_BIT   = 3;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned BIT_IDX_W = 3;
    localparam int unsigned STATUS_W  = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                       (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: address decode, combinational register reads,
// TX FIFO, overflow flag and an 8N1 serialiser with a registered tx line.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(BYTE_W - 1);

    tx_state_t              r_state;
    tx_state_t              w_state_n;
    logic [BAUD_W-1:0]      r_baud;
    logic [BAUD_W-1:0]      w_baud_n;
    logic [BIT_IDX_W-1:0]   r_bit;
    logic [BIT_IDX_W-1:0]   w_bit_n;
    logic [BYTE_W-1:0]      r_shreg;
    logic [BYTE_W-1:0]      w_shreg_n;
    logic                   r_tx;
    logic                   w_tx_n;
    logic                   r_ovf;

    logic                   w_off;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ovf_clr;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_busy;
    logic                   w_baud_done;
    logic [BYTE_W-1:0]      w_dout;
    logic [STATUS_W-1:0]    w_status;
    logic                   w_unused_ok;

    // Register decode; addr[1:0] and upper store-data bits are don't-cares.
    assign hit         = (addr[31:3] == BASE_ADDR[31:3]);
    assign w_off       = addr[2];
    assign w_push      = we & hit & (w_off == TXDATA_OFF);
    assign w_ovf_clr   = we & hit & (w_off == STATUS_OFF) & wdata[OVF_BIT];
    assign w_unused_ok = ^{addr[1:0], wdata[31:BYTE_W], wdata[BYTE_W-1:OVF_BIT+1],
                           wdata[OVF_BIT-1:0]};

    assign w_busy = (r_state != IDLE);

    always_comb begin
        w_status            = '0;
        w_status[FULL_BIT]  = w_full;
        w_status[EMPTY_BIT] = w_empty;
        w_status[BUSY_BIT]  = w_busy;
        w_status[OVF_BIT]   = r_ovf;
    end

    assign rdata = (hit && (w_off == STATUS_OFF)) ? 32'(w_status) : 32'h0;
    assign tx    = r_tx;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wdata[BYTE_W-1:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Overflow: a dropped push sets the flag and wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_push && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_shreg <= w_shreg_n;
            r_tx    <= w_tx_n;
        end
    end

    assign w_baud_done = (r_baud == BAUD_LAST);

    // Next-state logic; tx is derived from the next state so the line is registered.
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud;
        w_bit_n   = r_bit;
        w_shreg_n = r_shreg;
        w_pop     = 1'b0;
        w_tx_n    = 1'b1;

        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shreg_n = w_dout;
                    w_baud_n  = '0;
                    w_state_n = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_bit_n   = '0;
                    w_state_n = DATA;
                end else begin
                    w_baud_n = r_baud + BAUD_W'(1);
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_shreg_n = {1'b0, r_shreg[BYTE_W-1:1]};
                    w_bit_n   = r_bit + BIT_IDX_W'(1);
                    if (r_bit == BIT_LAST) w_state_n = STOP;
                end else begin
                    w_baud_n = r_baud + BAUD_W'(1);
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    w_baud_n  = '0;
                    w_state_n = IDLE;
                end else begin
                    w_baud_n = r_baud + BAUD_W'(1);
                end
            end
            default: w_state_n = IDLE;
        endcase

        case (w_state_n)
            START:   w_tx_n = 1'b0;
            DATA:    w_tx_n = w_shreg_n[0];
            default: w_tx_n = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register reads, frame timing, FIFO full/overflow,
// mid-frame reset and out-of-window writes, with a background serial decoder.
module tb_mmio_uart_tx;

    localparam logic [31:0] TXD_A = 32'h0001_0000;
    localparam logic [31:0] STS_A = 32'h0001_0004;
    localparam int          CPB   = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    logic        we    = 1'b0;
    logic        hit;
    logic [31:0] rdata;
    logic        tx;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    int         st_q[$];
    int         frame_err = 0;

    int         mon_s;
    logic [7:0] mon_b;
    logic       mon_ok;

    mmio_uart_tx #(
        .BASE_ADDR    (32'h0001_0000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .hit   (hit),
        .rdata (rdata),
        .tx    (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Serial decoder: samples mid-bit starting from the first low sample.
    initial begin
        forever begin
            @(posedge clk); #2;
            if (tx === 1'b0) begin
                mon_s  = cyc;
                mon_ok = 1'b1;
                repeat (2) @(posedge clk);
                #2;
                if (tx !== 1'b0) mon_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #2;
                    mon_b[i] = tx;
                end
                repeat (CPB) @(posedge clk);
                #2;
                if (tx !== 1'b1) mon_ok = 1'b0;
                rx_q.push_back(mon_b);
                st_q.push_back(mon_s);
                if (!mon_ok) frame_err++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
        wdata = '0;
    endtask

    task automatic rd_sts(output logic [31:0] v);
        addr = STS_A;
        #1;
        v = rdata;
    endtask

    task automatic flush();
        rx_q.delete();
        st_q.delete();
        frame_err = 0;
    endtask

    task automatic wait_frames(input string tag, input int n);
        int k;
        k = 0;
        while (rx_q.size() < n && k < 600) begin
            tick();
            k++;
        end
        chk(tag, 64'(rx_q.size() >= n), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        int k;
        k = 0;
        rd_sts(s);
        while (s != 32'h2 && k < 200) begin
            tick();
            rd_sts(s);
            k++;
        end
        repeat (3) tick();
        chk(tag, 64'(s), 64'h2);
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) chk(tag, 64'(rx_q[i]), 64'(first + 8'(i)));
        end
        chk({tag, "_framing"}, 64'(frame_err), 64'd0);
    endtask

    logic [31:0] s;
    logic [39:0] exp_w;
    logic [39:0] obs_w;
    logic [7:0]  b55;
    logic        low_seen;
    int          k;

    initial begin
        // 1: reset and combinational reads
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        addr = STS_A;
        #1;
        chk("rst_hit", 64'(hit), 64'd1);
        chk("rst_status", 64'(rdata), 64'h2);
        chk("rst_tx", 64'(tx), 64'd1);
        addr = 32'h0001_0007;
        #1;
        chk("status_alias", 64'(rdata), 64'h2);
        addr = TXD_A;
        #1;
        chk("txdata_read", 64'(rdata), 64'h0);
        addr = 32'h0000_0000;
        #1;
        chk("miss_hit", 64'(hit), 64'd0);
        chk("miss_rdata", 64'(rdata), 64'h0);

        // 2: single frame waveform
        flush();
        b55 = 8'h55;
        for (int j = 1; j <= 40; j++) begin
            if (j <= CPB)            exp_w[j-1] = 1'b0;
            else if (j <= 9 * CPB)   exp_w[j-1] = b55[(j - CPB - 1) / CPB];
            else                     exp_w[j-1] = 1'b1;
        end
        wr(TXD_A, 32'hAB55);
        chk("push_tx_idle", 64'(tx), 64'd1);
        rd_sts(s);
        chk("push_status", 64'(s), 64'h0);
        for (int j = 1; j <= 40; j++) begin
            tick();
            obs_w[j-1] = tx;
            if (j == 20) begin
                rd_sts(s);
                chk("frame_status", 64'(s), 64'h6);
            end
        end
        chk("frame_wave", 64'(obs_w), 64'(exp_w));
        tick();
        chk("after_tx", 64'(tx), 64'd1);
        rd_sts(s);
        chk("after_status", 64'(s), 64'h2);
        repeat (5) tick();

        // 3: five back-to-back bytes fill the FIFO without overflow
        flush();
        for (int i = 1; i <= 5; i++) wr(TXD_A, 32'(i));
        rd_sts(s);
        chk("fill_status", 64'(s), 64'h5);
        wait_frames("fill_frames", 5);
        chk_bytes("fill_byte", 8'h01, 5);
        for (int i = 0; i < 4; i++) begin
            if (i + 1 < st_q.size()) chk("fill_spacing", 64'(st_q[i+1] - st_q[i]), 64'd41);
        end
        wait_idle("fill_idle");

        // 4: sixth byte overflows, then clear ovf
        flush();
        for (int i = 1; i <= 6; i++) wr(TXD_A, 32'(i));
        rd_sts(s);
        chk("ovf_status", 64'(s), 64'hD);
        wr(STS_A, 32'h8);
        rd_sts(s);
        chk("ovf_clr_status", 64'(s), 64'h5);
        wait_frames("ovf_frames", 5);
        chk_bytes("ovf_byte", 8'h01, 5);
        repeat (60) tick();
        chk("ovf_count", 64'(rx_q.size()), 64'd5);
        wait_idle("ovf_idle");

        // 7: push while full in the same cycle as a pop is accepted
        flush();
        for (int i = 0; i < 5; i++) wr(TXD_A, 32'h11 + 32'(i));
        rd_sts(s);
        k = 0;
        while (s[2] && k < 100) begin
            tick();
            rd_sts(s);
            k++;
        end
        chk("pp_idle_seen", 64'(s), 64'h1);
        wr(TXD_A, 32'h16);
        rd_sts(s);
        chk("pp_status", 64'(s), 64'h5);
        wait_frames("pp_frames", 6);
        chk_bytes("pp_byte", 8'h11, 6);
        wait_idle("pp_idle");

        // 5: reset mid-frame aborts and discards
        flush();
        wr(TXD_A, 32'h55);
        wr(TXD_A, 32'h66);
        k = 0;
        while (tx !== 1'b0 && k < 10) begin
            tick();
            k++;
        end
        chk("rst_fall", 64'(tx), 64'd0);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_tx", 64'(tx), 64'd1);
        rd_sts(s);
        chk("midrst_status", 64'(s), 64'h2);
        low_seen = 1'b0;
        for (int j = 0; j < 100; j++) begin
            tick();
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        chk("midrst_quiet", 64'(low_seen), 64'd0);
        flush();

        // 6: write outside the window
        addr  = 32'h0001_0008;
        wdata = 32'hFF;
        we    = 1'b1;
        #1;
        chk("oow_hit", 64'(hit), 64'd0);
        chk("oow_rdata", 64'(rdata), 64'h0);
        tick();
        we = 1'b0;
        rd_sts(s);
        chk("oow_status", 64'(s), 64'h2);
        low_seen = 1'b0;
        for (int j = 0; j < 60; j++) begin
            tick();
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        chk("oow_quiet", 64'(low_seen), 64'd0);
        chk("oow_frames", 64'(rx_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
